// File: rtl/eoc_readout_slave_if.sv
// Wishbone classic 8-bit bus bundle for the EOC readout slave.
// Carries the master-driven request signals and the slave-driven
// ack/val/data return slice that feeds the downstream bus mux.
interface eoc_readout_slave_if;
    logic       wb_cyc_i;
    logic       wb_stb_i;
    logic       wb_we_i;
    logic [7:0] wb_adr_i;
    logic [7:0] wb_dat_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       wb_val_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_val_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_val_o
    );
endinterface

// File: rtl/eoc_readout_slave.sv
// End-of-column readout buffer for one double column.
// Hit words are captured into a DEPTH-entry FIFO and read out by a
// Wishbone master as bytes: STATUS, DATA_LO, DATA_HI, DROPS, CTRL.
// Optional macro EOC_TIMESTAMP_EN adds an 8-bit timestamp per entry,
// readable at offset 5, which then becomes the popping read.
module eoc_readout_slave #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] BASE  = 8'h10,
    parameter int         HIT_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n_i,
    input  logic             hit_valid_i,
    input  logic [HIT_W-1:0] hit_data_i,
    eoc_readout_slave_if.slave wb,
    output logic             fifo_empty_o,
    output logic             fifo_full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef EOC_TIMESTAMP_EN
    localparam int       EW      = HIT_W + 8;
    localparam bit [2:0] POP_OFF = 3'd5;
`else
    localparam int       EW      = HIT_W;
    localparam bit [2:0] POP_OFF = 3'd2;
`endif

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_drops;
    logic          r_ack;
    logic [7:0]    r_dat;
    logic          r_empty, r_full;
`ifdef EOC_TIMESTAMP_EN
    logic [7:0]    r_ts;
`endif

    logic          w_sel, w_go, w_rd, w_wr;
    logic [2:0]    w_off;
    logic          w_full_now, w_nonempty;
    logic          w_pop, w_flush, w_clr_drops, w_push, w_drop;
    logic [CW-1:0] w_cnt_nxt;
    logic [EW-1:0] w_head, w_entry;
    logic [7:0]    w_cnt8;
    logic [7:0]    w_rdat;
    logic          w_unused;

    assign w_sel       = wb.wb_cyc_i & wb.wb_stb_i & (wb.wb_adr_i[7:3] == BASE[7:3]);
    assign w_off       = wb.wb_adr_i[2:0];
    // A new access is only taken while no ack is outstanding.
    assign w_go        = w_sel & ~r_ack;
    assign w_rd        = w_go & ~wb.wb_we_i;
    assign w_wr        = w_go &  wb.wb_we_i;

    assign w_full_now  = (r_cnt == CW'(DEPTH));
    assign w_nonempty  = (r_cnt != '0);
    assign w_head      = r_mem[r_rp];
    assign w_cnt8      = 8'(r_cnt);

    // Empty-FIFO reads of the popping offset return zero and do not pop.
    assign w_pop       = w_rd & (w_off == POP_OFF) & w_nonempty;
    assign w_flush     = w_wr & (w_off == 3'd4) & wb.wb_dat_i[0];
    assign w_clr_drops = w_wr & (w_off == 3'd4) & wb.wb_dat_i[1];
    // A same-edge pop frees a slot, so a full FIFO still accepts the push.
    assign w_push      = hit_valid_i & ~w_flush & (~w_full_now | w_pop);
    assign w_drop      = hit_valid_i & ~w_flush & w_full_now & ~w_pop;

    assign w_unused    = ^{wb.wb_dat_i[7:2]};

`ifdef EOC_TIMESTAMP_EN
    assign w_entry = {r_ts, hit_data_i};
`else
    assign w_entry = hit_data_i;
`endif

    // Next occupancy: flush clears, otherwise push and pop net out.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_flush)
            w_cnt_nxt = '0;
        else if (w_push && !w_pop)
            w_cnt_nxt = r_cnt + CW'(1);
        else if (w_pop && !w_push)
            w_cnt_nxt = r_cnt - CW'(1);
    end

    // Read data mux, sampled from the pre-edge head and counters.
    always_comb begin
        w_rdat = 8'h00;
        if (w_rd) begin
            case (w_off)
                3'd0: w_rdat = {r_full, r_empty, 2'b00, w_cnt8[3:0]};
                3'd1: if (w_nonempty) w_rdat = w_head[7:0];
                3'd2: if (w_nonempty) w_rdat = w_head[15:8];
                3'd3: w_rdat = r_drops;
`ifdef EOC_TIMESTAMP_EN
                3'd5: if (w_nonempty) w_rdat = w_head[23:16];
`endif
                default: w_rdat = 8'h00;
            endcase
        end
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge wb_clk_i) begin
        if (w_push)
            r_mem[r_wp] <= w_entry;
    end

    // Pointers, occupancy flags and drop counter.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_drops <= 8'h00;
            r_empty <= 1'b1;
            r_full  <= 1'b0;
        end else begin
            if (w_flush) begin
                r_wp <= '0;
                r_rp <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop)  r_rp <= r_rp + AW'(1);
            end
            r_cnt   <= w_cnt_nxt;
            r_empty <= (w_cnt_nxt == '0);
            r_full  <= (w_cnt_nxt == CW'(DEPTH));
            if (w_clr_drops)
                r_drops <= 8'h00;
            else if (w_drop && r_drops != 8'hFF)
                r_drops <= r_drops + 8'h01;
        end
    end

    // Bus response: one-cycle ack/val with data, zero data otherwise.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            r_ack <= 1'b0;
            r_dat <= 8'h00;
        end else begin
            r_ack <= w_go;
            r_dat <= w_rdat;
        end
    end

`ifdef EOC_TIMESTAMP_EN
    // Free-running wrapping timestamp stored with each pushed word.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i)
            r_ts <= 8'h00;
        else
            r_ts <= r_ts + 8'h01;
    end
`endif

    assign wb.wb_ack_o  = r_ack;
    assign wb.wb_val_o  = r_ack;
    assign wb.wb_dat_o  = r_dat;
    assign fifo_empty_o = r_empty;
    assign fifo_full_o  = r_full;
endmodule

// File: doc/eoc_readout_slave.md
Name: eoc_readout_slave

Overview:
- Per-double-column end-of-column (EOC) readout buffer with an 8-bit Wishbone classic slave port.
- Captures 16-bit hit words from one double column into a small FIFO and serves them to the Wishbone master as byte reads.
- One instance per double column. Its wb_ack_o, wb_dat_o and wb_val_o drive one slice of the downstream bus multiplexer's ack, data and valid inputs.

Parameters:
- DEPTH, 8, FIFO depth in hit words; power of two, 2..16.
- BASE, 8'h10, Wishbone base address. Window is BASE[7:3], 8 byte registers.
- HIT_W, 16, hit word width; fixed at 16 (two bytes).

Ports:
- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_n_i  in  1  synchronous active-low reset.
- hit_valid_i  in  1  single-cycle hit strobe from the double column; no backpressure.
- hit_data_i  in  16  hit word {row[7:0], tot[7:0]}.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_we_i  in  1  write enable.
- wb_adr_i  in  8  byte address.
- wb_dat_i  in  8  write data.
- wb_dat_o  out  8  read data; valid while wb_ack_o=1.
- wb_ack_o  out  1  single-cycle acknowledge.
- wb_val_o  out  1  slave-selected flag to the bus mux; identical timing to wb_ack_o.
- fifo_empty_o  out  1  FIFO empty.
- fifo_full_o  out  1  FIFO full.

Behaviour:
- Reset (wb_rst_n_i=0 at a clock edge):
  - Pointers, count, drop counter and timestamp cleared.
  - wb_ack_o=0, wb_val_o=0, wb_dat_o=8'h00, fifo_empty_o=1, fifo_full_o=0.
  - Reset mid-transaction aborts it: no ack is issued for a strobe sampled in the reset cycle.
- Address select:
  - sel = wb_cyc_i & wb_stb_i & (wb_adr_i[7:3]==BASE[7:3]); offset = wb_adr_i[2:0].
  - Outside the window the slave never asserts ack or val.
- Handshake:
  - If sel=1 and ack_q=0 at edge N, then wb_ack_o=1 and wb_val_o=1 for exactly cycle N+1. The register side effect commits at edge N.
  - A strobe held high produces ack on alternate cycles (ack, gap, ack).
  - wb_dat_o returns to 8'h00 when ack=0.
- Register map:
  - 0 STATUS (R): {full, empty, 2'b0, count[3:0]}.
  - 1 DATA_LO (R): head word tot byte; no pop.
  - 2 DATA_HI (R): head word row byte; pops the head.
  - 3 DROPS (R): 8-bit saturating dropped-hit counter.
  - 4 CTRL (W): bit0 flush FIFO, bit1 clear DROPS; self-clearing; reads 8'h00.
  - 5-7: read 8'h00, writes ignored, still acked.
  - Writes to read-only offsets are acked and ignored. Reads of CTRL are acked and return 8'h00.
- Empty FIFO: DATA_LO and DATA_HI return 8'h00 and cause no pop; ack is still issued.
- Push rule:
  - hit_valid_i=1 and not full: word written at the write pointer; count increments.
  - hit_valid_i=1 and full: word dropped; DROPS increments, saturating at 8'hFF.
- Simultaneous push and pop in the same edge:
  - Count unchanged.
  - When full, the push succeeds because the pop frees a slot; no drop.
  - When empty, the pop is suppressed (empty-read rule) and the push is taken.
- Flush and push in the same edge: flush wins, the push is discarded and is not counted as a drop.
- CTRL bit1 and a drop in the same edge: clear wins; DROPS=0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- fifo_empty_o and fifo_full_o are registered and reflect count after each edge.

Optional Feature:
- Macro: EOC_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 8-bit wrapping timestamp counter, cleared on reset.
  - Each pushed word stores a 24-bit entry {ts, row, tot}, with ts sampled on the push edge.
  - Offset 5 becomes DATA_TS (R): head timestamp, and pops.
  - DATA_HI no longer pops; the read order becomes LO, HI, TS.
- Undefined: no timestamp logic or storage; offset 5 reads 8'h00; DATA_HI pops.

Test Plan:
- Reset, then read STATUS at BASE+0 -> ack one cycle after strobe, val=ack, dat=8'h40 (empty).
- Push hits 16'hA512, 16'h3307; read offsets 1,2,1,2 -> 8'h12, 8'hA5, 8'h07, 8'h33; STATUS ends at 8'h40.
- Push DEPTH+3 hits with no reads -> STATUS=8'h88 for DEPTH=8, DROPS=8'h03. Write CTRL=8'h02 -> DROPS=8'h00, FIFO contents intact.
- FIFO full, and a DATA_HI read commits in the same edge as hit_valid_i -> no drop, count stays 8, new word is last out.
- Access wb_adr_i=BASE+8 -> no ack and no val for 4 cycles. Read DATA_HI on empty -> ack, dat=8'h00, count remains 0.
- Assert reset while a strobe is sampled -> no ack next cycle, all outputs at reset values. With EOC_TIMESTAMP_EN: push 3 cycles apart -> DATA_TS difference = 3.
